// File: rtl/adc_spi_responder.sv
// SPI-mode-0 responder that emulates a 10-bit ADC.
// A frame is a start bit, four config bits (SGL/DIFF, D2..D0), two null-bit
// clocks and ten data clocks that return the sample latched at CS fall.
// spi_clk, spi_cs and spi_mosi are oversampled in the clk domain.
module adc_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [9:0] sample_in,
    output logic [2:0] channel,
    output logic       single_ended,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_error
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CONFIG,
        NULL_BIT,
        DATA,
        TRAIL
    } state_t;

    localparam logic [2:0] SETTLE_CYCLES = 3'(SYNC_STAGES);

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_dly, cs_dly;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   sclk_active;

    logic [2:0] settle_cnt;
    logic       armed;

    logic [4:0] k_q, k_d;
    logic [9:0] sample_q;
    logic [2:0] cfg_q;
    logic [3:0] data_idx;

    logic start_frame;
    logic cfg_load;
    logic done_d, error_d, miso_d;

    // Saturating bit-counter increment: stops at 16, never wraps.
    function automatic logic [4:0] k_inc(input logic [4:0] k);
        return (k >= 5'd16) ? 5'd16 : k + 5'd1;
    endfunction

    // Synchronizer chains plus one extra delayed flop for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_dly  <= 1'b0;
            cs_dly    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_dly  <= sclk_sync[SYNC_STAGES-1];
            cs_dly    <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // spi_clk edges count only while CS is low; the cycle in which CS is seen
    // rising still counts so a last clock coinciding with CS release completes.
    assign sclk_active = !(cs_s && cs_dly);
    assign sclk_rise   = sclk_s && !sclk_dly && sclk_active;
    assign sclk_fall   = !sclk_s && sclk_dly && sclk_active;
    assign cs_rise     = cs_s && !cs_dly;
    assign cs_fall     = !cs_s && cs_dly;

    // Arm frame start only after the synchronizers have flushed their reset
    // value and CS has been seen high, so a CS held low across reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE_CYCLES) begin
                settle_cnt <= settle_cnt + 3'd1;
            end
            if (settle_cnt == SETTLE_CYCLES && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bit-counter logic.
    // NOTE: every always_comb output gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (start_frame) begin
                    state_d = WAIT_START;
                    k_d     = '0;
                end
            end
            WAIT_START: begin
                if (sclk_rise && mosi_s) begin
                    state_d = CONFIG;
                    k_d     = '0;
                end
            end
            CONFIG: begin
                if (sclk_rise) begin
                    k_d = k_inc(k_q);
                    if (k_q == 5'd3) begin
                        state_d = NULL_BIT;
                    end
                end
            end
            NULL_BIT: begin
                if (sclk_rise) begin
                    k_d = k_inc(k_q);
                    if (k_q == 5'd5) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    k_d = k_inc(k_q);
                    if (k_q == 5'd15) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                state_d = TRAIL;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_q != IDLE && cs_rise) begin
            state_d = IDLE;
        end
    end

    assign start_frame = (state_q == IDLE) && cs_fall && armed;
    assign data_idx    = 4'd15 - k_q[3:0];

    // Output decode: completion/abort pulses, config capture, MISO data bit.
    always_comb begin
        done_d   = (state_q == DATA) && sclk_rise && (k_q == 5'd15);
        error_d  = cs_rise && !done_d &&
                   (state_q inside {WAIT_START, CONFIG, NULL_BIT, DATA});
        cfg_load = (state_q == CONFIG) && sclk_rise && (k_q == 5'd3);
        miso_d   = 1'b0;
        if (state_d == DATA) begin
            if (state_q == DATA && sclk_fall) begin
                miso_d = sample_q[data_idx];
            end else begin
                miso_d = spi_miso;
            end
        end
    end

    // Datapath registers: counter, latched sample, config and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q          <= '0;
            sample_q     <= '0;
            cfg_q        <= '0;
            channel      <= '0;
            single_ended <= 1'b0;
            spi_miso     <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            k_q         <= k_d;
            spi_miso    <= miso_d;
            frame_done  <= done_d;
            frame_error <= error_d;
            if (start_frame) begin
                sample_q <= sample_in;
            end
            if (state_q == CONFIG && sclk_rise) begin
                cfg_q <= {cfg_q[1:0], mosi_s};
            end
            if (cfg_load) begin
                {single_ended, channel} <= {cfg_q, mosi_s};
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: drives a mode-0 SPI master at 1.5625 MHz,
// checks returned bytes through a scoreboard queue, plus abort and reset cases.
module tb_adc_spi_responder;

    localparam int S    = 2;
    localparam int HALF = 32;   // spi_clk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk, spi_cs, spi_mosi, spi_miso;
    logic [9:0] sample_in;
    logic [2:0] channel;
    logic       single_ended, busy, frame_done, frame_error;

    adc_spi_responder #(.SYNC_STAGES(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_clk      (spi_clk),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .sample_in    (sample_in),
        .channel      (channel),
        .single_ended (single_ended),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  sample;
        int          n;
        logic [31:0] tx;    // byte i at [31-8*i -: 8]
        logic [31:0] rx;
        logic [2:0]  ch;
        logic        sgl;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [7:0] exp_q[$];

    // Pulse monitor, sampled on the falling edge away from updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) done_cnt++;
            if (frame_error) err_cnt++;
            if (frame_done && frame_error) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sclk_cycle(input logic mosi, input logic cs_on_rise, output logic miso_s);
        spi_mosi = mosi;
        repeat (HALF) @(negedge clk);
        miso_s  = spi_miso;
        spi_clk = 1'b1;
        if (cs_on_rise) spi_cs = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input logic cs_last, input string tag);
        int d0, e0;
        logic [7:0] rxb, txb, expb;
        logic m;
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < v.n; i++) exp_q.push_back(v.rx[31-8*i -: 8]);
        sample_in = v.sample;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        sample_in = ~v.sample;  // must not affect returned data
        for (int i = 0; i < v.n; i++) begin
            txb = v.tx[31-8*i -: 8];
            for (int b = 7; b >= 0; b--) begin
                sclk_cycle(txb[b], cs_last && (i == v.n - 1) && (b == 0), m);
                rxb[b] = m;
            end
            if (exp_q.size() == 0) begin
                check({tag, " scoreboard empty"}, 32'd1, 32'd0);
            end else begin
                expb = exp_q.pop_front();
                check($sformatf("%s rx byte %0d", tag, i), {24'd0, rxb}, {24'd0, expb});
            end
        end
        if (!cs_last) begin
            repeat (HALF) @(negedge clk);
            spi_cs = 1'b1;
        end
        repeat (3 * S + 8) @(negedge clk);
        check({tag, " frame_done count"}, done_cnt - d0, 1);
        check({tag, " frame_error count"}, err_cnt - e0, 0);
        check({tag, " busy after frame"}, {31'd0, busy}, 0);
        check({tag, " channel"}, {29'd0, channel}, {29'd0, v.ch});
        check({tag, " single_ended"}, {31'd0, single_ended}, {31'd0, v.sgl});
    endtask

    task automatic abort_frame(input logic [15:0] bits, input int nclk,
                               input logic [2:0] exp_ch, input logic exp_sgl, input string tag);
        int d0, e0;
        logic m;
        d0 = done_cnt;
        e0 = err_cnt;
        sample_in = 10'h2A5;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nclk; i++) sclk_cycle(bits[15-i], 1'b0, m);
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (S + 2) @(negedge clk);
        check({tag, " busy low after CS rise"}, {31'd0, busy}, 0);
        repeat (10) @(negedge clk);
        check({tag, " frame_error count"}, err_cnt - e0, 1);
        check({tag, " frame_done count"}, done_cnt - d0, 0);
        check({tag, " channel"}, {29'd0, channel}, {29'd0, exp_ch});
        check({tag, " single_ended"}, {31'd0, single_ended}, {31'd0, exp_sgl});
    endtask

    initial begin
        vec_t vecs[7];
        int d0, e0;
        logic m, saw_busy;

        vecs[0] = '{10'h2A5, 3, 32'h0180_0000, 32'h0002_A500, 3'd0, 1'b1};
        vecs[1] = '{10'h3FF, 3, 32'h01B0_0000, 32'h0003_FF00, 3'd3, 1'b1};
        vecs[2] = '{10'h155, 4, 32'h0001_0000, 32'h0000_0155, 3'd0, 1'b0};
        vecs[3] = '{10'h0C3, 3, 32'h01F0_0000, 32'h0000_C300, 3'd7, 1'b1};
        vecs[4] = '{10'h200, 3, 32'h01C0_0000, 32'h0002_0000, 3'd4, 1'b1};
        vecs[5] = '{10'h000, 3, 32'h0180_0000, 32'h0000_0000, 3'd0, 1'b1};
        vecs[6] = '{10'h1E1, 3, 32'h8000_0000, 32'h00F0_8000, 3'd0, 1'b0};

        rst       = 1'b1;
        spi_clk   = 1'b0;
        spi_cs    = 1'b1;
        spi_mosi  = 1'b0;
        sample_in = 10'h0;
        repeat (5) @(negedge clk);
        check("reset spi_miso", {31'd0, spi_miso}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset channel", {29'd0, channel}, 0);
        check("reset single_ended", {31'd0, single_ended}, 0);
        check("reset frame_done", {31'd0, frame_done}, 0);
        check("reset frame_error", {31'd0, frame_error}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // CS released after 12 clocks (k=4 reached): config updated, error pulse.
        abort_frame(16'h0180, 12, 3'd0, 1'b1, "abort_k4");
        // CS released after 10 clocks (k=2): config keeps previous values.
        abort_frame(16'h01F0, 10, 3'd0, 1'b1, "abort_k2");
        run_frame(vecs[0], 1'b0, "after_abort");

        // CS rise coinciding with the last data clock: done, no error.
        run_frame(vecs[1], 1'b1, "cs_on_last");

        // Reset mid-frame: no pulses, and CS held low must not restart a frame.
        d0 = done_cnt;
        e0 = err_cnt;
        sample_in = 10'h2A5;
        repeat (4) @(negedge clk);
        spi_cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) sclk_cycle(i == 7 || i == 8, 1'b0, m);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid spi_miso", {31'd0, spi_miso}, 0);
        check("rst_mid busy", {31'd0, busy}, 0);
        check("rst_mid channel", {29'd0, channel}, 0);
        saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sclk_cycle(1'b1, 1'b0, m);
            if (busy || spi_miso) saw_busy = 1'b1;
        end
        check("rst_mid no activity with CS low", {31'd0, saw_busy}, 0);
        check("rst_mid frame_done count", done_cnt - d0, 0);
        check("rst_mid frame_error count", err_cnt - e0, 0);
        spi_cs = 1'b1;
        repeat (20) @(negedge clk);
        run_frame(vecs[1], 1'b0, "after_rst");

        check("done and error never together", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth on spi_clk, spi_cs and spi_mosi; legal range 2..4.
REQ-002 clk  input  1  system clock, 100 MHz; one clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 spi_clk  input  1  SPI clock from master; mode 0 (idle low, master samples MISO on rising edge).
REQ-005 spi_cs  input  1  chip select from master, active-low.
REQ-006 spi_mosi  input  1  data from master, MSB first.
REQ-007 spi_miso  output  1  data to master, registered.
REQ-008 sample_in  input  10  conversion value to return; unsigned.
REQ-009 channel  output  3  channel field D2..D0 from the last config, registered.
REQ-010 single_ended  output  1  SGL/DIFF bit from the last config, registered.
REQ-011 busy  output  1  high while a frame is in progress (state not IDLE).
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes with all 10 data bits shifted out.
REQ-013 frame_error  output  1  one-cycle pulse when CS deasserts before frame completion.

Function
REQ-014 Each of spi_clk, spi_cs and spi_mosi SHALL pass through SYNC_STAGES flops; edges SHALL be detected by comparing the last synchronized stage with one extra delayed flop.
REQ-015 Correct operation is required for an spi_clk period of at least 8 clk cycles, with each high and low phase at least 4 clk cycles.
REQ-016 States: IDLE, WAIT_START, CONFIG, NULL_BIT, DATA, TRAIL.
REQ-017 IDLE: on detected CS falling edge, latch sample_in into an internal 10-bit register and go to WAIT_START. sample_in changes later in the frame SHALL have no effect.
REQ-018 WAIT_START: on each spi_clk rising edge, sample MOSI. Zeros SHALL be ignored. A 1 is the start bit: clear bit counter k and go to CONFIG.
REQ-019 CONFIG: sample MOSI on rising edges k=1..4 into SGL/DIFF, D2, D1, D0. After k=4, update single_ended and channel together, then go to NULL_BIT.
REQ-020 NULL_BIT: covers rising edges k=5 (don't-care) and k=6 (null bit); MISO SHALL be 0 for both.
REQ-021 DATA: rising edges k=7..16 return D9..D0 of the latched sample.
REQ-022 MISO timing: the value for rising edge k SHALL be driven within 2 clk cycles after the detected spi_clk falling edge that precedes edge k. The value for k=7 (D9) SHALL be driven after the falling edge following k=6.
REQ-023 spi_miso SHALL be 0 at all times outside DATA, including WAIT_START, CONFIG, NULL_BIT, TRAIL and IDLE.
REQ-024 After rising edge k=16: pulse frame_done for one cycle, go to TRAIL, and drive MISO 0 on any further clocks until CS rises.
REQ-025 Detected CS rising edge in any state: go to IDLE next cycle.
  - In WAIT_START, CONFIG, NULL_BIT or DATA: pulse frame_error for one cycle.
  - In TRAIL: no pulse.
  - channel and single_ended SHALL keep their values unless k=4 was reached.
REQ-026 A CS rising edge in the same cycle as the k=16 rising edge SHALL produce frame_done and no frame_error.
REQ-027 frame_done and frame_error SHALL never assert in the same cycle.
REQ-028 Bit counter: 5 bits, saturating at 16; no wrap-around.
REQ-029 spi_clk edges detected while CS is synchronized high SHALL be ignored.

Reset
REQ-030 Reset values while rst=1 at a clk edge: state IDLE; spi_miso 0; channel 0; single_ended 0; busy 0; frame_done 0; frame_error 0; counter 0; latched sample 0. Synchronizer flops reset to: spi_cs 1, spi_clk 0, spi_mosi 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no frame_done or frame_error pulse. Afterwards the block SHALL wait for a fresh CS falling edge; a CS already low at reset release SHALL NOT start a frame.

Verification
REQ-032 sample_in=10'h2A5, master sends 0x01, 0x80, 0x00 at 1.5625 MHz -> MISO bytes read 0x00, 0x02, 0xA5; channel=0, single_ended=1; one frame_done pulse.
REQ-033 sample_in=10'h3FF, bytes 0x01, 0xB0, 0x00 -> second byte read 0x03, third 0xFF; channel=3, single_ended=1.
REQ-034 Bytes 0x00, 0x01, 0x00, 0x00 (late start bit, differential ch0) with sample_in=10'h155 -> fourth byte 0x55, third byte low bits 2'b01; single_ended=0.
REQ-035 CS raised after 12 spi_clk cycles of a 0x01, 0x80 frame -> one frame_error pulse, no frame_done, busy low within SYNC_STAGES+2 cycles; the next full frame returns the correct data.
REQ-036 sample_in changed from 10'h000 to 10'h3FF after the CS fall -> data read is 10'h000.
REQ-037 rst pulsed for 1 cycle after 10 spi_clk cycles with CS held low -> spi_miso 0 and busy 0; no activity until CS is raised and lowered again.
